// File: rtl/instr_boot_loader.sv
// instr_boot_loader
// Receives a program over a byte stream (16-bit little-endian word-count
// header, then little-endian program bytes). Writes it into instruction memory
// one word at a time, and releases the CPU from reset only after a complete,
// valid load. Every output is either a register or a decode of the state.

module instr_boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-2:0] o_words_loaded
);

  // One extra bit above the word address, so the count can reach MAX_WORDS
  // without wrapping.
  localparam int WC_W = ADDR_W - 1;
  localparam logic [16:0] MAX_WORDS = 17'(1) << (ADDR_W - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [15:0]     r_len;
  logic [1:0]      r_byte_idx;
  logic [WC_W-1:0] r_word_idx;
  logic [31:0]     r_wdata;

  logic            w_xfer;
  logic [15:0]     w_len_full;
  logic            w_last_word;

  // In HDR1, the length decision must include the high byte that is arriving
  // in this same cycle.
  assign w_len_full  = {i_in_data, r_len[7:0]};
  assign w_last_word = ((16'(r_word_idx) + 16'd1) == r_len);
  assign w_xfer      = i_in_valid & o_in_ready;

  assign o_mem_addr     = {r_word_idx[ADDR_W-3:0], 2'b00};
  assign o_mem_wdata    = r_wdata;
  assign o_words_loaded = r_word_idx;

  // State register; reset aborts any load in progress.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and Moore output decode.
  always_comb begin
    w_next     = r_state;
    o_in_ready = 1'b0;
    o_mem_we   = 1'b0;
    o_cpu_rst  = 1'b1;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_err      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_HDR0;
      end
      S_HDR0: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b1;
        if (i_in_valid) w_next = S_HDR1;
      end
      S_HDR1: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b1;
        if (i_in_valid) begin
          if (w_len_full == 16'd0)                   w_next = S_DONE;
          else if ({1'b0, w_len_full} > MAX_WORDS)   w_next = S_ERR;
          else                                       w_next = S_DATA;
        end
      end
      S_DATA: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b1;
        if (i_in_valid && (r_byte_idx == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        o_mem_we = 1'b1;
        o_busy   = 1'b1;
        w_next   = w_last_word ? S_DONE : S_DATA;
      end
      S_DONE: begin
        o_done    = 1'b1;
        o_cpu_rst = 1'b0;
      end
      S_ERR: begin
        o_err = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Header latch, byte-lane assembly and word counting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len      <= '0;
      r_byte_idx <= '0;
      r_word_idx <= '0;
      r_wdata    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_word_idx <= '0;
            r_byte_idx <= '0;
          end
        end
        S_HDR0: begin
          if (w_xfer) r_len[7:0] <= i_in_data;
        end
        S_HDR1: begin
          if (w_xfer) begin
            r_len[15:8] <= i_in_data;
            r_byte_idx  <= '0;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_wdata[{r_byte_idx, 3'b000} +: 8] <= i_in_data;
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          r_word_idx <= r_word_idx + 1'b1;
          r_byte_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/instr_boot_loader.md
Name: instr_boot_loader

Overview:
- Upstream of the MIPS single-cycle CPU. Loads the program into instruction memory from a byte stream, then releases the CPU from reset.
- The stream is a 16-bit little-endian word-count header, followed by program bytes in little-endian order.
- The block holds the CPU in reset until the load completes successfully. It replaces file preloading in system-level benches and on the board.

Parameters:
- ADDR_W, 10, instruction-memory byte-address width. MAX_WORDS = 2^(ADDR_W-2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  block accepts a byte. A transfer occurs when in_valid && in_ready at posedge.
- mem_we  out  1  instruction-memory word write enable.
- mem_addr  out  ADDR_W  byte address of the word being written; always word aligned ([1:0]=0).
- mem_wdata  out  32  assembled word.
- cpu_rst  out  1  reset to the CPU; high until a successful load.
- busy  out  1  high in HDR0, HDR1, DATA and WRITE.
- done  out  1  load complete.
- err  out  1  header word count exceeds MAX_WORDS.
- words_loaded  out  ADDR_W-1  number of words written so far.

Behaviour:
- Reset (rst=1 at posedge):
  - state goes to IDLE.
  - cpu_rst=1; in_ready, mem_we, busy, done and err are 0.
  - mem_addr=0, mem_wdata=0, words_loaded=0.
  - Internal count, byte index and word index are cleared.
- All outputs are Moore decodes of registered state, or registers themselves. There is no combinational in-to-out path.
- IDLE:
  - cpu_rst=1, in_ready=0.
  - start moves to HDR0 and clears words_loaded and the word index.
- HDR0: in_ready=1. On a transfer, latch len[7:0] and move to HDR1.
- HDR1: in_ready=1. On a transfer, latch len[15:8]. The decision uses the full 16-bit len, including the byte just received:
  - len==0: go to DONE.
  - len>MAX_WORDS: go to ERR.
  - otherwise: go to DATA with byte index 0.
- DATA:
  - in_ready=1.
  - A transfer places in_data in lane byte_idx: lane 0 is [7:0], lane 3 is [31:24].
  - On byte_idx==3 go to WRITE; otherwise increment byte_idx.
  - Cycles with in_valid=0 hold all state.
- WRITE (exactly one cycle):
  - in_ready=0, mem_we=1.
  - mem_addr = word_idx*4; mem_wdata = the assembled word.
  - At the closing edge: word_idx++, words_loaded++, byte_idx=0.
  - If the new word_idx==len, go to DONE; otherwise go to DATA.
- Latency and throughput:
  - 4th byte accepted at edge t: mem_we is high during cycle t..t+1 (the cycle following the edge).
  - Peak throughput is one word per 5 cycles.
- DONE:
  - done=1, cpu_rst=0, starting the cycle after the last WRITE (or after HDR1 when len==0).
  - in_ready=0; start is ignored.
  - The state is sticky until rst.
- ERR:
  - err=1, cpu_rst=1, in_ready=0.
  - No memory writes occur; the state is sticky until rst.
- start while not in IDLE is ignored.
- len==MAX_WORDS is legal. The last word is written at address (MAX_WORDS-1)*4, and words_loaded reaches MAX_WORDS with no wrap.
- rst mid-load aborts at once and returns to IDLE with cpu_rst=1. Memory words already written are not cleared. The next load restarts at address 0, lane 0.
- rst and start in the same cycle: rst wins.

Test Plan:
1. Reset: hold rst for 2 cycles with in_valid=1 -> cpu_rst=1; in_ready, mem_we, done and err are 0; words_loaded=0.
2. Two-word load:
   - Stimulus: start, then back-to-back bytes 02 00 | 20 08 00 00 | 22 10 43 00.
   - Required: mem_we pulses at addr 0x000 with data 0x00000820, then at addr 0x004 with data 0x00431022.
   - Each pulse is one cycle after the 4th byte of its word.
   - done=1 and cpu_rst=0 the cycle after the second write; words_loaded=2; in_ready=0 afterwards.
3. Empty program: header 00 00 -> done=1 and cpu_rst=0 one cycle after the 2nd header byte; mem_we never asserts.
4. Oversize (ADDR_W=10):
   - Header 01 01 (257 words) -> err=1, cpu_rst=1, in_ready=0, no mem_we.
   - A further start is ignored until rst.
5. Gapped stream: same bytes as test 2 with in_valid low 1-3 cycles between bytes -> identical writes and data; no write before the 4th byte of each word.
6. Reset mid-load:
   - Stimulus: rst asserted after header 01 00 and 2 data bytes.
   - Required: IDLE with cpu_rst=1. A new load 01 00 | AA BB CC DD then writes 0xDDCCBBAA at addr 0, and done=1.
